// File: rtl/bounce_gen.sv
// Mechanical-button emulator: one press/hold/release sequence per accepted start, with bounce segments.
// Define BOUNCE_GEN_LFSR_EN for pseudo-random segment lengths; otherwise every segment is BOUNCE_MAX cycles.
module bounce_gen #(
  parameter int unsigned BOUNCES     = 4,
  parameter int unsigned HOLD_CYCLES = 1000,
  parameter int unsigned BOUNCE_MAX  = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic btn_out,
  output logic busy,
  output logic done
);

  localparam int unsigned CNT_W  = $clog2(BOUNCE_MAX + 1);
  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [4:0] LAST_SEG = (BOUNCES == 0) ? 5'd0 : 5'(2 * BOUNCES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PRESS, HOLD, RELEASE} state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  seg_cnt, seg_cnt_n, seg_load;
  logic [4:0]        seg_idx, seg_idx_n;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_n;
  logic              btn_n, busy_n, done_n;

`ifdef BOUNCE_GEN_LFSR_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       lfsr <= 8'hA5;
    else if (busy) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  // Counter holds remaining cycles minus one, so the load is I-1 = lfsr mod BOUNCE_MAX.
  assign seg_load = CNT_W'(lfsr % 8'(BOUNCE_MAX));
`else
  assign seg_load = CNT_W'(BOUNCE_MAX - 1);
`endif

  always_comb begin
    state_n    = state;
    seg_cnt_n  = seg_cnt;
    seg_idx_n  = seg_idx;
    hold_cnt_n = hold_cnt;
    btn_n      = btn_out;
    busy_n     = busy;
    done_n     = 1'b0;
    case (state)
      IDLE: begin
        btn_n  = 1'b0;
        busy_n = 1'b0;
        // done high marks the completion cycle; a start landing there is dropped.
        if (start && !done) begin
          busy_n = 1'b1;
          btn_n  = 1'b1;
          if (BOUNCES == 0) begin
            state_n    = HOLD;
            hold_cnt_n = HOLD_LOAD;
          end else begin
            state_n   = PRESS;
            seg_idx_n = '0;
            seg_cnt_n = seg_load;
          end
        end
      end
      PRESS: begin
        if (seg_cnt != '0) begin
          seg_cnt_n = seg_cnt - 1'b1;
        end else if (seg_idx == LAST_SEG) begin
          state_n    = HOLD;
          hold_cnt_n = HOLD_LOAD;
          btn_n      = 1'b1;
        end else begin
          seg_idx_n = seg_idx + 5'd1;
          seg_cnt_n = seg_load;
          btn_n     = ~btn_out;
        end
      end
      HOLD: begin
        if (hold_cnt != '0) begin
          hold_cnt_n = hold_cnt - 1'b1;
        end else if (BOUNCES == 0) begin
          state_n = IDLE;
          btn_n   = 1'b0;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end else begin
          state_n   = RELEASE;
          seg_idx_n = '0;
          seg_cnt_n = seg_load;
          btn_n     = 1'b0;
        end
      end
      RELEASE: begin
        if (seg_cnt != '0) begin
          seg_cnt_n = seg_cnt - 1'b1;
        end else if (seg_idx == LAST_SEG) begin
          state_n = IDLE;
          btn_n   = 1'b0;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end else begin
          seg_idx_n = seg_idx + 5'd1;
          seg_cnt_n = seg_load;
          btn_n     = ~btn_out;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      seg_cnt  <= '0;
      seg_idx  <= '0;
      hold_cnt <= '0;
      btn_out  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      seg_cnt  <= seg_cnt_n;
      seg_idx  <= seg_idx_n;
      hold_cnt <= hold_cnt_n;
      btn_out  <= btn_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

endmodule

// File: tb/tb_bounce_gen.sv
// Bench for bounce_gen: three instances checked against a cycle-offset waveform model,
// literal waveform tables, segment/edge properties and a behavioural debouncer.
module tb_bounce_gen;

  localparam int B0 = 2, H0 = 10, M0 = 4;
  localparam int B1 = 0, H1 = 10, M1 = 4;
  localparam int B2 = 4, H2 = 20, M2 = 8;

  logic       clk;
  logic       rst;
  logic [2:0] start;
  logic [2:0] btn, busy, done;

  int tests = 0;
  int fails = 0;

  int bb[3] = '{B0, B1, B2};
  int hh[3] = '{H0, H1, H2};
  int mm[3] = '{M0, M1, M2};
  int k[3];
  int db_total = 0;

`ifdef BOUNCE_GEN_LFSR_EN
  bit [2:0] chk_en = 3'b010;
`else
  bit [2:0] chk_en = 3'b111;
`endif

  bounce_gen #(.BOUNCES(B0), .HOLD_CYCLES(H0), .BOUNCE_MAX(M0)) u0 (
    .clk(clk), .rst(rst), .start(start[0]), .btn_out(btn[0]), .busy(busy[0]), .done(done[0]));
  bounce_gen #(.BOUNCES(B1), .HOLD_CYCLES(H1), .BOUNCE_MAX(M1)) u1 (
    .clk(clk), .rst(rst), .start(start[1]), .btn_out(btn[1]), .busy(busy[1]), .done(done[1]));
  bounce_gen #(.BOUNCES(B2), .HOLD_CYCLES(H2), .BOUNCE_MAX(M2)) u2 (
    .clk(clk), .rst(rst), .start(start[2]), .btn_out(btn[2]), .busy(busy[2]), .done(done[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Expected {btn, busy, done} at offset kk cycles after the accepted start (0 = idle).
  function automatic logic [2:0] model_out(input int kk, input int b, input int m, input int h);
    int p = 2 * b * m;
    if (kk == 0) return 3'b000;
    if (kk <= p) return {(((kk - 1) / m) % 2) == 0, 1'b1, 1'b0};
    if (kk <= p + h) return 3'b110;
    if (kk <= 2 * p + h) return {(((kk - p - h - 1) / m) % 2) == 1, 1'b1, 1'b0};
    return 3'b001;
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 3; i++) begin
      if (rst)                                  k[i] <= 0;
      else if (k[i] == 0)                       k[i] <= start[i] ? 1 : 0;
      else if (k[i] == 4 * bb[i] * mm[i] + hh[i] + 1) k[i] <= 0;
      else                                      k[i] <= k[i] + 1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int i = 0; i < 3; i++) begin
          if (chk_en[i])
            check($sformatf("model_u%0d_btn_busy_done", i), int'({btn[i], busy[i], done[i]}),
                  int'(model_out(k[i], bb[i], mm[i], hh[i])));
        end
      end
    end
  end

  // Segment-length and edge-count properties on u2, valid with or without random intervals.
  initial begin
    logic pm_prev;
    int   pm_run, pm_pr, pm_rr;
    bit   pm_valid, pm_hold;
    pm_prev = 0; pm_run = 0; pm_pr = 0; pm_rr = 0; pm_valid = 0; pm_hold = 0;
    forever begin
      @(negedge clk or posedge rst);
      if (rst) begin
        pm_prev = 0; pm_run = 0; pm_pr = 0; pm_rr = 0; pm_valid = 0; pm_hold = 0;
      end else begin
        if (busy[2] || done[2]) begin
          if (btn[2] != pm_prev) begin
            if (pm_valid) begin
              check("seg_len_in_range", int'(pm_run <= M2 || (pm_run == H2 && !pm_hold && pm_prev)), 1);
              if (pm_run > M2) pm_hold = 1;
            end
            if (btn[2]) begin
              if (pm_hold) pm_rr++;
              else         pm_pr++;
            end
            pm_run = 1;
            pm_valid = 1;
          end else begin
            pm_run++;
          end
          if (done[2]) begin
            check("press_hold_rises", pm_pr, B2 + 1);
            check("release_rises", pm_rr, B2);
            check("hold_seen", int'(pm_hold), 1);
            pm_run = 0; pm_pr = 0; pm_rr = 0; pm_valid = 0; pm_hold = 0;
          end
        end else begin
          pm_run = 0; pm_pr = 0; pm_rr = 0; pm_valid = 0; pm_hold = 0;
        end
        pm_prev = btn[2];
      end
    end
  end

  // Debouncer fed by u2: flips after 9 consecutive disagreeing cycles, counts press pulses.
  initial begin
    logic deb;
    int   dcnt;
    deb = 0; dcnt = 0;
    forever begin
      @(negedge clk or posedge rst);
      if (rst) begin
        deb = 0; dcnt = 0;
      end else if (btn[2] == deb) begin
        dcnt = 0;
      end else if (dcnt == 8) begin
        if (!deb) db_total++;
        deb = ~deb;
        dcnt = 0;
      end else begin
        dcnt++;
      end
    end
  end

  task automatic pulse(input int i);
    start[i] = 1'b1;
    @(posedge clk);
    #1 start[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done[i] && n < budget);
    check($sformatf("wait_done_u%0d", i), int'(done[i]), 1);
  endtask

  function automatic bit lit_btn026(input int c);
    return (c >= 1 && c <= 4) || (c >= 9 && c <= 12) || (c >= 17 && c <= 26) ||
           (c >= 31 && c <= 34) || (c >= 39 && c <= 42);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int r1, f1, nd, snap;
    logic p1;
    rst = 0;
    start = '0;
    #2 rst = 1;
    #1;
    for (int i = 0; i < 3; i++)
      check($sformatf("reset_outputs_u%0d", i), int'({btn[i], busy[i], done[i]}), 0);
    repeat (3) @(posedge clk);
    #2 rst = 0;

    // Cycle 0: start u0 and u1 together; u0 gets a second start in cycle 20.
    @(posedge clk);
    #1 start[0] = 1'b1; start[1] = 1'b1;
    @(posedge clk);
    #1 start[1] = 1'b0;
    r1 = 0; f1 = 0; p1 = 0;
    for (int c = 1; c <= 45; c++) begin
      start[0] = (c == 20);
      @(negedge clk);
`ifndef BOUNCE_GEN_LFSR_EN
      check($sformatf("r026_btn_c%0d", c), int'(btn[0]), int'(lit_btn026(c)));
      check($sformatf("r026_busy_c%0d", c), int'(busy[0]), int'(c <= 42));
      check($sformatf("r026_done_c%0d", c), int'(done[0]), int'(c == 43));
`endif
      check($sformatf("r027_btn_c%0d", c), int'(btn[1]), int'(c <= 10));
      check($sformatf("r027_done_c%0d", c), int'(done[1]), int'(c == 11));
      if (btn[1] && !p1) r1++;
      if (!btn[1] && p1) f1++;
      p1 = btn[1];
      @(posedge clk);
      #1;
    end
    start[0] = 1'b0;
    check("r027_rising_edges", r1, 1);
    check("r027_falling_edges", f1, 1);

    // Start held through the done cycle must not launch a new sequence.
    @(posedge clk);
    #1 pulse(0);
    wait_done(0, 2000);
    start[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    @(negedge clk);
    check("start_at_done_ignored", int'(busy[0]), 0);

    // Asynchronous reset in the middle of PRESS.
    @(posedge clk);
    #1 pulse(2);
    repeat (2) @(posedge clk);
    #2 check("press_busy_before_rst", int'(busy[2]), 1);
    rst = 1'b1;
    #1 check("rst_async_btn", int'(btn[2]), 0);
    check("rst_async_busy", int'(busy[2]), 0);
    check("rst_async_done", int'(done[2]), 0);
    #1 rst = 1'b0;
    nd = 0;
    repeat (60) begin
      @(negedge clk);
      if (done[2]) nd++;
    end
    check("no_done_after_rst", nd, 0);
    @(posedge clk);
    #1 pulse(2);
    @(negedge clk);
    check("fresh_start_busy", int'(busy[2]), 1);
    check("fresh_start_btn", int'(btn[2]), 1);
    wait_done(2, 2000);

    // Three sequences through the debouncer, each started after the previous done.
    for (int s = 0; s < 3; s++) begin
      repeat (16) @(negedge clk);
      snap = db_total;
      @(posedge clk);
      #1 pulse(2);
      wait_done(2, 2000);
      repeat (16) @(negedge clk);
      check($sformatf("debounce_pulses_seq%0d", s), db_total - snap, 1);
    end

    // Random start traffic on all instances.
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) start[i] = ($urandom_range(0, 7) == 0);
    end
    start = '0;
    repeat (200) @(posedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bounce_gen.md
BOUNCE_GEN -- requirements
Module: bounce_gen

Interface
REQ-001 SHALL have parameter BOUNCES, default 4: number of bounce pulses per edge, range 0..15.
REQ-002 SHALL have parameter HOLD_CYCLES, default 1000: stable-pressed duration in clk cycles, range 1..2^20-1.
REQ-003 SHALL have parameter BOUNCE_MAX, default 8: maximum bounce segment length in cycles, range 1..255.
REQ-004 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset; one clock; reset is asynchronous and active-high.
REQ-006 SHALL have port start  input  1  request one press/release sequence, sampled each cycle.
REQ-007 SHALL have port btn_out  output  1  emulated raw button level, registered, feeds a debouncer's btn_in.
REQ-008 SHALL have port busy  output  1  high while a sequence is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse at sequence completion.

Function
REQ-010 SHALL implement FSM states IDLE, PRESS, HOLD, RELEASE.
REQ-011 IDLE: btn_out=0, busy=0; start=1 -> PRESS (or HOLD if BOUNCES=0); btn_out=1 and busy=1 from the next cycle.
REQ-012 PRESS: 2*BOUNCES segments, levels alternating 1,0,1,0,...; each segment lasts the current interval I cycles; after the last segment -> HOLD.
REQ-013 HOLD: btn_out=1 for exactly HOLD_CYCLES cycles; then -> RELEASE (or IDLE if BOUNCES=0).
REQ-014 RELEASE: 2*BOUNCES segments, levels alternating 0,1,0,1,...; each segment I cycles; after the last -> IDLE with btn_out=0.
REQ-015 Completion: done=1 and busy=0 in the first IDLE cycle after a sequence; done=0 at all other times.
REQ-016 start while busy=1 SHALL be ignored, not queued; start coinciding with done SHALL be ignored.
REQ-017 Interval I SHALL be reloaded at every segment start; I is always in 1..BOUNCE_MAX, never 0.
REQ-018 Segment and hold counters SHALL be wide enough for BOUNCE_MAX and HOLD_CYCLES without wrap; no overflow is permitted.
REQ-019 btn_out SHALL change only on segment or phase boundaries, never mid-segment.

Reset
REQ-020 rst=1 SHALL immediately force IDLE, btn_out=0, busy=0, done=0, and all counters 0, regardless of clk.
REQ-021 Reset mid-sequence SHALL abort the sequence with no done pulse; the first start after rst deasserts SHALL begin a fresh sequence.
REQ-022 Reset SHALL reseed the LFSR to 8'hA5 when BOUNCE_GEN_LFSR_EN is defined.

Configuration
REQ-023 With BOUNCE_GEN_LFSR_EN defined:
- an 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5) advances every cycle while busy=1;
- I = (lfsr mod BOUNCE_MAX) + 1, sampled at segment start.
REQ-024 Without BOUNCE_GEN_LFSR_EN: no LFSR logic; I = BOUNCE_MAX for every segment, giving a fully deterministic waveform.

Verification
REQ-025 Reset: assert rst mid-PRESS -> btn_out=0, busy=0, done=0 before the next clk edge; no done pulse follows.
REQ-026 Macro off, BOUNCES=2, BOUNCE_MAX=4, HOLD_CYCLES=10, start at cycle 0:
- btn_out: 1 in cycles 1-4, 0 in 5-8, 1 in 9-12, 0 in 13-16, 1 in 17-26 (hold);
- release: 0 in 27-30, 1 in 31-34, 0 in 35-38, 1 in 39-42, 0 from 43;
- done=1 only in cycle 43; busy=0 from cycle 43.
REQ-027 Macro off, BOUNCES=0, HOLD_CYCLES=10 -> btn_out=1 in cycles 1-10, done in cycle 11; exactly one rising and one falling edge.
REQ-028 start pulsed again in cycle 20 of the REQ-026 run -> waveform identical to REQ-026; no second sequence runs.
REQ-029 Macro on, BOUNCES=4, BOUNCE_MAX=8 -> every segment length is in 1..8; btn_out rising edges = 5 in PRESS+HOLD, 4 in RELEASE.
REQ-030 Macro on, btn_out driving the debounce block:
- debouncer's btn_pressed pulses exactly once per sequence, for 3 back-to-back sequences;
- bench runs 3 back-to-back sequences, each started after done.
